// File: rtl/gpr_regfile.sv
// ============================================================================
// Module   : gpr_regfile
// Purpose  : 32x64 GPR file with two registered read ports and two write ports.
//            Define REGS_WRITE_BYPASS_EN to forward same-edge write data to reads.
// Revision : 1.0
// ============================================================================
`default_nettype none

module gpr_regfile #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              readEn0,
  input  logic [0:ADDR_W-1] readAddr0,
  output logic [0:DATA_W-1] readData0,
  input  logic              readEn1,
  input  logic [0:ADDR_W-1] readAddr1,
  output logic [0:DATA_W-1] readData1,
  input  logic              writeEn0,
  input  logic [0:ADDR_W-1] writeAddr0,
  input  logic [0:DATA_W-1] writeData0,
  input  logic              writeEn1,
  input  logic [0:ADDR_W-1] writeAddr1,
  input  logic [0:DATA_W-1] writeData1
);

  logic [0:DATA_W-1] regs [NUM_REGS];
  logic [0:DATA_W-1] rd_next0;
  logic [0:DATA_W-1] rd_next1;

  // Lane 1 is applied last so it wins when both lanes target one register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (writeEn0) begin
        regs[writeAddr0] <= writeData0;
      end
      if (writeEn1) begin
        regs[writeAddr1] <= writeData1;
      end
    end
  end

  always_comb begin
    rd_next0 = regs[readAddr0];
    rd_next1 = regs[readAddr1];
`ifdef REGS_WRITE_BYPASS_EN
    if (writeEn0 && (writeAddr0 == readAddr0)) rd_next0 = writeData0;
    if (writeEn1 && (writeAddr1 == readAddr0)) rd_next0 = writeData1;
    if (writeEn0 && (writeAddr0 == readAddr1)) rd_next1 = writeData0;
    if (writeEn1 && (writeAddr1 == readAddr1)) rd_next1 = writeData1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      readData0 <= '0;
      readData1 <= '0;
    end else begin
      if (readEn0) begin
        readData0 <= rd_next0;
      end
      if (readEn1) begin
        readData1 <= rd_next1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gpr_regfile.sv
// ============================================================================
// Module   : tb_gpr_regfile
// Purpose  : Directed + random self-checking bench for gpr_regfile.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_gpr_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        readEn0, readEn1, writeEn0, writeEn1;
  logic [0:4]  readAddr0, readAddr1, writeAddr0, writeAddr1;
  logic [0:63] readData0, readData1, writeData0, writeData1;

  int compared   = 0;
  int mismatched = 0;

  logic [63:0] model [32];
  logic [63:0] q0 [$];
  logic [63:0] q1 [$];

  always #5 clk = ~clk;

  gpr_regfile dut (
    .clk(clk), .rst(rst),
    .readEn0(readEn0), .readAddr0(readAddr0), .readData0(readData0),
    .readEn1(readEn1), .readAddr1(readAddr1), .readData1(readData1),
    .writeEn0(writeEn0), .writeAddr0(writeAddr0), .writeData0(writeData0),
    .writeEn1(writeEn1), .writeAddr1(writeAddr1), .writeData1(writeData1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model_read(input logic [4:0] ra, input logic we0,
      input logic [4:0] wa0, input logic [63:0] wd0, input logic we1,
      input logic [4:0] wa1, input logic [63:0] wd1);
    logic [63:0] v;
    v = model[ra];
`ifdef REGS_WRITE_BYPASS_EN
    if (we0 && wa0 == ra) v = wd0;
    if (we1 && wa1 == ra) v = wd1;
`else
    if (we0 || we1 || wa0 != wa1 || wd0 != wd1) v = model[ra];
`endif
    return v;
  endfunction

  // One clock: drive at negedge, queue expected read results, compare after the edge.
  task automatic step(input logic r, input logic re0, input logic [4:0] ra0,
      input logic re1, input logic [4:0] ra1,
      input logic we0, input logic [4:0] wa0, input logic [63:0] wd0,
      input logic we1, input logic [4:0] wa1, input logic [63:0] wd1);
    bit p0, p1;
    @(negedge clk);
    rst = r; readEn0 = re0; readAddr0 = ra0; readEn1 = re1; readAddr1 = ra1;
    writeEn0 = we0; writeAddr0 = wa0; writeData0 = wd0;
    writeEn1 = we1; writeAddr1 = wa1; writeData1 = wd1;
    p0 = r || re0;
    p1 = r || re1;
    if (p0) q0.push_back(r ? 64'h0 : model_read(ra0, we0, wa0, wd0, we1, wa1, wd1));
    if (p1) q1.push_back(r ? 64'h0 : model_read(ra1, we0, wa0, wd0, we1, wa1, wd1));
    if (r) begin
      for (int i = 0; i < 32; i++) model[i] = 64'h0;
    end else begin
      if (we0) model[wa0] = wd0;
      if (we1) model[wa1] = wd1;
    end
    @(posedge clk);
    #1;
    if (p0) check("rd0", readData0, q0.pop_front());
    if (p1) check("rd1", readData1, q1.pop_front());
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    step(0, 1, a0, 1, a1, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [63:0] hold;
    for (int i = 0; i < 32; i++) model[i] = 64'hDEAD;

    // Reset for two cycles, then every register reads zero on both ports.
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("reset_rd0", readData0, 64'h0);
    check("reset_rd1", readData1, 64'h0);
    for (int i = 0; i < 32; i++) rd(5'(i), 5'(31 - i));

    // Basic write then read on the other port.
    step(0, 0, 0, 0, 0, 1, 5, 64'h0123_4567_89AB_CDEF, 0, 0, 0);
    hold = readData0;
    step(0, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0);
    check("basic_rd1", readData1, 64'h0123_4567_89AB_CDEF);
    check("basic_rd0_hold", readData0, hold);

    // Same-address collision: lane 1 wins; different addresses both commit.
    step(0, 0, 0, 0, 0, 1, 7, 64'h1111, 1, 7, 64'h2222);
    rd(7, 7);
    check("collide_rd0", readData0, 64'h2222);
    check("collide_rd1", readData1, 64'h2222);
    step(0, 0, 0, 0, 0, 1, 3, 64'hA, 1, 4, 64'hB);
    rd(3, 4);
    check("dual_rd0", readData0, 64'hA);
    check("dual_rd1", readData1, 64'hB);

    // Read and write of the same register at the same edge.
    step(0, 0, 0, 0, 0, 1, 9, 64'h5, 0, 0, 0);
    step(0, 1, 9, 0, 0, 1, 9, 64'h6, 0, 0, 0);
`ifdef REGS_WRITE_BYPASS_EN
    check("rw_same_edge", readData0, 64'h6);
`else
    check("rw_same_edge", readData0, 64'h5);
`endif
    rd(9, 9);
    check("rw_reread", readData0, 64'h6);
    step(0, 1, 9, 1, 9, 0, 0, 0, 1, 9, 64'h77);
`ifdef REGS_WRITE_BYPASS_EN
    check("rw_lane1", readData1, 64'h77);
`else
    check("rw_lane1", readData1, 64'h6);
`endif

    // Hold while read port 0 is disabled.
    step(0, 0, 0, 0, 0, 1, 2, 64'hFF, 0, 0, 0);
    rd(2, 0);
    step(0, 0, 0, 0, 0, 1, 2, 64'h0, 0, 0, 0);
    check("hold_1", readData0, 64'hFF);
    step(0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0);
    check("hold_2", readData0, 64'hFF);
    rd(2, 2);
    check("hold_release", readData0, 64'h0);

    // Reset in the middle of traffic overrides the writes and reads.
    step(0, 0, 0, 0, 0, 1, 1, 64'h1234, 1, 2, 64'h5678);
    step(1, 1, 1, 1, 2, 1, 1, 64'hAAAA, 1, 2, 64'hBBBB);
    check("rst_mid_rd0", readData0, 64'h0);
    check("rst_mid_rd1", readData1, 64'h0);
    for (int i = 0; i < 32; i++) rd(5'(i), 5'((i + 7) % 32));
    step(0, 0, 0, 0, 0, 1, 1, 64'hCAFE_F00D, 0, 0, 0);
    rd(1, 1);
    check("post_rst_write", readData0, 64'hCAFE_F00D);

    // Random traffic against the model, small address range to force collisions.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 49) == 0),
           1'($urandom), 5'($urandom_range(0, 7)),
           1'($urandom), 5'($urandom_range(0, 7)),
           1'($urandom), 5'($urandom_range(0, 7)), {$urandom, $urandom},
           1'($urandom), 5'($urandom_range(0, 7)), {$urandom, $urandom});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
